// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical-memory port between an I-cache and a D-cache.
// One transaction is granted at a time; the granted client's strobes, address
// and write data are steered to pmem, and pmem_resp is returned only to it.
// Optional feature macro: ARB_ROUND_ROBIN_EN -- when defined, a last_grant
// register alternates the grant when both clients are pending; otherwise the
// D-cache always wins.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              icache_pmem_read,
  input  logic [ADDR_W-1:0] icache_pmem_address,
  output logic [LINE_W-1:0] icache_pmem_rdata,
  output logic              icache_pmem_resp,
  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [ADDR_W-1:0] dcache_pmem_address,
  input  logic [LINE_W-1:0] dcache_pmem_wdata,
  output logic [LINE_W-1:0] dcache_pmem_rdata,
  output logic              dcache_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  // state   | meaning
  // IDLE    | no grant; strobes and responses low, arbitrating pending requests
  // SERVE_I | I-cache owns pmem until pmem_resp or it drops its request
  // SERVE_D | D-cache owns pmem until pmem_resp or it drops its request
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t state, state_nxt;
  logic   i_pending, d_pending, pick_d;

  assign i_pending = icache_pmem_read;
  assign d_pending = dcache_pmem_read | dcache_pmem_write;

  // Fill data is broadcast; only the resp strobe identifies the owner.
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_d;

  // Remember which client won the most recent grant (reset to I so D wins first).
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_d <= 1'b0;
    end else if (state == IDLE && state_nxt == SERVE_D) begin
      last_grant_d <= 1'b1;
    end else if (state == IDLE && state_nxt == SERVE_I) begin
      last_grant_d <= 1'b0;
    end
  end

  assign pick_d = d_pending & (~i_pending | ~last_grant_d);
`else
  assign pick_d = d_pending;
`endif

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and pmem steering; resp is gated by the live request so a
  // withdrawn request never sees a late response.
  always_comb begin
    state_nxt        = state;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
    case (state)
      IDLE: begin
        if (pick_d) begin
          state_nxt = SERVE_D;
        end else if (i_pending) begin
          state_nxt = SERVE_I;
        end
      end
      SERVE_I: begin
        pmem_read        = icache_pmem_read;
        pmem_address     = icache_pmem_address;
        icache_pmem_resp = pmem_resp & i_pending;
        if (pmem_resp || !i_pending) begin
          state_nxt = IDLE;
        end
      end
      SERVE_D: begin
        pmem_read        = dcache_pmem_read;
        pmem_write       = dcache_pmem_write;
        pmem_address     = dcache_pmem_address;
        pmem_wdata       = dcache_pmem_wdata;
        dcache_pmem_resp = pmem_resp & d_pending;
        if (pmem_resp || !d_pending) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks with a grant scoreboard for mem_arbiter.
module tb_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              icache_pmem_read;
  logic [ADDR_W-1:0] icache_pmem_address;
  logic [LINE_W-1:0] icache_pmem_rdata;
  logic              icache_pmem_resp;
  logic              dcache_pmem_read;
  logic              dcache_pmem_write;
  logic [ADDR_W-1:0] dcache_pmem_address;
  logic [LINE_W-1:0] dcache_pmem_wdata;
  logic [LINE_W-1:0] dcache_pmem_rdata;
  logic              dcache_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk),
    .reset(reset),
    .icache_pmem_read(icache_pmem_read),
    .icache_pmem_address(icache_pmem_address),
    .icache_pmem_rdata(icache_pmem_rdata),
    .icache_pmem_resp(icache_pmem_resp),
    .dcache_pmem_read(dcache_pmem_read),
    .dcache_pmem_write(dcache_pmem_write),
    .dcache_pmem_address(dcache_pmem_address),
    .dcache_pmem_wdata(dcache_pmem_wdata),
    .dcache_pmem_rdata(dcache_pmem_rdata),
    .dcache_pmem_resp(dcache_pmem_resp),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
  );

  typedef struct {
    logic              is_d;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic              drop;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return {8{a ^ 16'hBEEF}};
  endfunction

  function automatic exp_t mk(input logic is_d, input logic wr, input logic [ADDR_W-1:0] a,
                              input logic [LINE_W-1:0] wd, input logic drop);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = a; e.wdata = wd; e.drop = drop;
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    icache_pmem_read    = 1'b0;
    icache_pmem_address = '0;
    dcache_pmem_read    = 1'b0;
    dcache_pmem_write   = 1'b0;
    dcache_pmem_address = '0;
    dcache_pmem_wdata   = '0;
    pmem_rdata          = '0;
    pmem_resp           = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Waits (bounded) until a pmem strobe is up; w = cycles waited.
  task automatic wait_strobe(output int w);
    #2;
    w = 0;
    while (!(pmem_read || pmem_write) && w < 20) begin
      cyc();
      #2;
      w++;
    end
  endtask

  // Services the next granted transaction with pmem_resp lat cycles after the strobe.
  task automatic serve(input int lat, output int w);
    exp_t e;
    wait_strobe(w);
    n_cmp++;
    if (w >= 20 || sb.size() == 0) begin
      n_mis++;
      $display("FAIL serve_start: strobe=%b queued=%0d, required strobe=1 with a queued grant",
               pmem_read | pmem_write, sb.size());
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (pmem_write !== e.wr || pmem_read !== ~e.wr || pmem_address !== e.addr) begin
      n_mis++;
      $display("FAIL grant: rd=%b wr=%b addr=%h, required rd=%b wr=%b addr=%h",
               pmem_read, pmem_write, pmem_address, ~e.wr, e.wr, e.addr);
    end
    if (e.wr) begin
      n_cmp++;
      if (pmem_wdata !== e.wdata) begin
        n_mis++;
        $display("FAIL wdata: got %h, required %h", pmem_wdata, e.wdata);
      end
    end
    n_cmp++;
    if (icache_pmem_resp !== 1'b0 || dcache_pmem_resp !== 1'b0) begin
      n_mis++;
      $display("FAIL early_resp: i=%b d=%b, required 0 0", icache_pmem_resp, dcache_pmem_resp);
    end
    for (int i = 1; i < lat; i++) begin
      cyc();
      #2;
      n_cmp++;
      if (pmem_write !== e.wr || pmem_read !== ~e.wr || icache_pmem_resp !== 1'b0 ||
          dcache_pmem_resp !== 1'b0) begin
        n_mis++;
        $display("FAIL hold: rd=%b wr=%b iresp=%b dresp=%b, required rd=%b wr=%b resp 0 0",
                 pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp, ~e.wr, e.wr);
      end
    end
    if (lat > 0) begin
      cyc();
      #2;
    end
    pmem_rdata = line_of(e.addr);
    pmem_resp  = 1'b1;
    #1;
    n_cmp++;
    if (icache_pmem_resp !== ~e.is_d || dcache_pmem_resp !== e.is_d) begin
      n_mis++;
      $display("FAIL resp: i=%b d=%b, required i=%b d=%b",
               icache_pmem_resp, dcache_pmem_resp, ~e.is_d, e.is_d);
    end
    n_cmp++;
    if ((e.is_d ? dcache_pmem_rdata : icache_pmem_rdata) !== line_of(e.addr)) begin
      n_mis++;
      $display("FAIL rdata: got %h, required %h",
               e.is_d ? dcache_pmem_rdata : icache_pmem_rdata, line_of(e.addr));
    end
    cyc();
    pmem_resp = 1'b0;
    if (e.drop) begin
      if (e.is_d) begin
        dcache_pmem_read  = 1'b0;
        dcache_pmem_write = 1'b0;
      end else begin
        icache_pmem_read = 1'b0;
      end
    end
    #2;
    n_cmp++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      n_mis++;
      $display("FAIL idle_gap: rd=%b wr=%b, required 0 0", pmem_read, pmem_write);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    icache_pmem_read    = 1'b1;
    dcache_pmem_write   = 1'b1;
    pmem_rdata          = {4{32'hCAFE_F00D}};
    pmem_resp           = 1'b1;
    cyc();
    #2;
    n_cmp++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || icache_pmem_resp !== 1'b0 ||
        dcache_pmem_resp !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_outputs: rd=%b wr=%b iresp=%b dresp=%b, required all 0",
               pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp);
    end
    n_cmp++;
    if (icache_pmem_rdata !== {4{32'hCAFE_F00D}} || dcache_pmem_rdata !== {4{32'hCAFE_F00D}}) begin
      n_mis++;
      $display("FAIL rdata_bcast: i=%h d=%h, required %h",
               icache_pmem_rdata, dcache_pmem_rdata, {4{32'hCAFE_F00D}});
    end
    do_reset();
  endtask

  task automatic test_single_iread();
    int w;
    do_reset();
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h1230;
    sb.push_back(mk(1'b0, 1'b0, 16'h1230, '0, 1'b1));
    #1;
    n_cmp++;
    if (pmem_read !== 1'b0) begin
      n_mis++;
      $display("FAIL arb_latency0: pmem_read=%b in request cycle, required 0", pmem_read);
    end
    serve(3, w);
    n_cmp++;
    if (w != 1) begin
      n_mis++;
      $display("FAIL arb_latency: waited %0d cycles, required 1", w);
    end
  endtask

  task automatic test_priority();
    int w;
    do_reset();
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h2000;
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 16'h3000;
    dcache_pmem_wdata   = {4{32'h1357_9BDF}};
    sb.push_back(mk(1'b1, 1'b1, 16'h3000, {4{32'h1357_9BDF}}, 1'b1));
    sb.push_back(mk(1'b0, 1'b0, 16'h2000, '0, 1'b1));
    serve(2, w);
    serve(2, w);
    n_cmp++;
    if (w != 1) begin
      n_mis++;
      $display("FAIL back_to_back_gap: waited %0d cycles, required 1", w);
    end
  endtask

  task automatic test_continuous();
    int   w;
    logic order_d[4];
`ifdef ARB_ROUND_ROBIN_EN
    order_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    order_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    do_reset();
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 16'h4000;
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h5000;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(order_d[i], 1'b0, order_d[i] ? 16'h4000 : 16'h5000, '0, 1'b0));
    end
    for (int i = 0; i < 4; i++) begin
      serve(1, w);
    end
    clear_inputs();
    cyc();
    #2;
    n_cmp++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      n_mis++;
      $display("FAIL cont_quiesce: rd=%b wr=%b, required 0 0", pmem_read, pmem_write);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 16'h7000;
    dcache_pmem_wdata   = {4{32'hA5A5_5A5A}};
    wait_strobe(w);
    n_cmp++;
    if (pmem_write !== 1'b1 || w >= 20) begin
      n_mis++;
      $display("FAIL rst_mid_pre: pmem_write=%b, required 1", pmem_write);
    end
    reset = 1'b1;
    cyc();
    #2;
    n_cmp++;
    if (pmem_write !== 1'b0 || dcache_pmem_resp !== 1'b0) begin
      n_mis++;
      $display("FAIL rst_mid_post: wr=%b dresp=%b, required 0 0", pmem_write, dcache_pmem_resp);
    end
    pmem_rdata = line_of(16'h7000);
    pmem_resp  = 1'b1;
    #1;
    n_cmp++;
    if (dcache_pmem_resp !== 1'b0 || icache_pmem_resp !== 1'b0) begin
      n_mis++;
      $display("FAIL rst_mid_late_resp: i=%b d=%b, required 0 0",
               icache_pmem_resp, dcache_pmem_resp);
    end
    cyc();
    pmem_resp         = 1'b0;
    dcache_pmem_write = 1'b0;
    reset             = 1'b0;
    cyc();
  endtask

  task automatic test_drop();
    int w;
    do_reset();
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h6000;
    wait_strobe(w);
    n_cmp++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h6000) begin
      n_mis++;
      $display("FAIL drop_grant: rd=%b addr=%h, required 1 6000", pmem_read, pmem_address);
    end
    icache_pmem_read = 1'b0;
    cyc();
    pmem_rdata = line_of(16'h6000);
    pmem_resp  = 1'b1;
    #2;
    n_cmp++;
    if (icache_pmem_resp !== 1'b0 || dcache_pmem_resp !== 1'b0 || pmem_read !== 1'b0) begin
      n_mis++;
      $display("FAIL drop_late_resp: i=%b d=%b rd=%b, required 0 0 0",
               icache_pmem_resp, dcache_pmem_resp, pmem_read);
    end
    cyc();
    pmem_resp = 1'b0;
    #2;
    n_cmp++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      n_mis++;
      $display("FAIL drop_idle: rd=%b wr=%b, required 0 0", pmem_read, pmem_write);
    end
  endtask

  initial begin
    test_reset();
    test_single_iread();
    test_priority();
    test_continuous();
    test_reset_mid();
    test_drop();
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL scoreboard_drain: %0d grants left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
